// File: rtl/univ_reg_pkg.sv
// Shared types for the multi-mode register: mode encoding and serial-out select.
package univ_reg_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD = 3'b000,
    LOAD = 3'b001,
    SHL  = 3'b010,
    SHR  = 3'b011,
    UP   = 3'b100,
    DN   = 3'b101,
    ROL  = 3'b110,
    ROR  = 3'b111
  } mode_t;

  // Left-moving modes present the MSB on the serial output.
  function automatic logic so_from_msb(mode_t m);
    return (m == SHL) || (m == ROL);
  endfunction

endpackage

// File: rtl/univ_reg_if.sv
// Control/data bundle for univ_reg; clock and reset stay plain ports.
interface univ_reg_if import univ_reg_pkg::*; #(parameter int WIDTH = 4);
  logic              EN;
  logic              CLR;
  logic [MODE_W-1:0] M;
  logic [WIDTH-1:0]  D;
  logic              SI_R;
  logic              SI_L;
  logic [WIDTH-1:0]  Q;
  logic              SO;
  logic              TC;

  modport master (output EN, CLR, M, D, SI_R, SI_L, input Q, SO, TC);
  modport slave  (input EN, CLR, M, D, SI_R, SI_L, output Q, SO, TC);
endinterface

// File: rtl/univ_reg_bit.sv
// One bit slice: 8:1 next-state mux with clear/enable priority and a
// flop that resets asynchronously to its own reset value RV.
module univ_reg_bit import univ_reg_pkg::*; #(
  parameter logic RV = 1'b0
) (
  input  logic  gclk,
  input  logic  grst_n,
  input  logic  en,
  input  logic  clr,
  input  mode_t mode,
  input  logic  d,
  input  logic  shl_in,
  input  logic  shr_in,
  input  logic  rol_in,
  input  logic  ror_in,
  input  logic  cnt,
  output logic  q
);

  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RV;
    end else if (en) begin
      case (mode)
        HOLD:    q_d = q_q;
        LOAD:    q_d = d;
        SHL:     q_d = shl_in;
        SHR:     q_d = shr_in;
        UP, DN:  q_d = cnt;
        ROL:     q_d = rol_in;
        ROR:     q_d = ror_in;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) q_q <= RV;
    else         q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/univ_reg.sv
// Multi-mode WIDTH-bit register: load, shift, rotate, up/down count, with
// sync clear and async reset to RESET_VAL. Shared incrementer lives here.
module univ_reg import univ_reg_pkg::*; #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic        C,
  input  logic        R,
  univ_reg_if.slave   bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] cnt;
  mode_t            mode;

  assign mode = mode_t'(bus.M);

  // One adder serves both directions: adding all-ones is a decrement.
  assign cnt = q + ((mode == DN) ? {WIDTH{1'b1}} : {{(WIDTH-1){1'b0}}, 1'b1});

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic shl_in, shr_in, rol_in, ror_in;

      if (i == 0) begin : g_lsb
        assign shl_in = bus.SI_R;
        assign rol_in = q[WIDTH-1];
      end else begin : g_nlsb
        assign shl_in = q[i-1];
        assign rol_in = q[i-1];
      end

      if (i == WIDTH-1) begin : g_msb
        assign shr_in = bus.SI_L;
        assign ror_in = q[0];
      end else begin : g_nmsb
        assign shr_in = q[i+1];
        assign ror_in = q[i+1];
      end

      univ_reg_bit #(.RV(RESET_VAL[i])) u_bit (
        .gclk   (C),
        .grst_n (R),
        .en     (bus.EN),
        .clr    (bus.CLR),
        .mode   (mode),
        .d      (bus.D[i]),
        .shl_in (shl_in),
        .shr_in (shr_in),
        .rol_in (rol_in),
        .ror_in (ror_in),
        .cnt    (cnt[i]),
        .q      (q[i])
      );
    end
  endgenerate

  assign bus.Q  = q;
  assign bus.SO = so_from_msb(mode) ? q[WIDTH-1] : q[0];
  // Gated by R so TC stays low while reset is held.
  assign bus.TC = R & bus.EN & ~bus.CLR &
                  (((mode == UP) & (&q)) | ((mode == DN) & ~(|q)));

  always @(posedge C) begin
    if (R && bus.EN === 1'b1) assert (!$isunknown(bus.M));
  end

endmodule

// File: tb/tb_univ_reg.sv
// Directed vectors for univ_reg (WIDTH=4, RESET_VAL=4'hA) with a queue-based scoreboard.
module tb_univ_reg;
  import univ_reg_pkg::*;

  logic C = 1'b0;
  logic R = 1'b1;

  univ_reg_if #(.WIDTH(4)) bus ();

  univ_reg #(.WIDTH(4), .RESET_VAL(4'hA)) dut (
    .C   (C),
    .R   (R),
    .bus (bus)
  );

  always #5 C = ~C;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic       so;
    logic       tc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input string fld, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  always @(negedge C) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "Q",  bus.Q,         e.q);
      chk(e.name, "SO", {3'b0, bus.SO}, {3'b0, e.so});
      chk(e.name, "TC", {3'b0, bus.TC}, {3'b0, e.tc});
    end
  end

  // Apply inputs just after a rising edge and queue the outputs expected
  // before the next rising edge (Q from the previous edge, TC/SO from new inputs).
  task automatic step(input string nm, input logic r, input logic en, input logic clr,
                      input logic [2:0] m, input logic [3:0] d, input logic sir, input logic sil,
                      input logic [3:0] eq, input logic eso, input logic etc);
    exp_t e;
    @(posedge C);
    #1;
    R = r; bus.EN = en; bus.CLR = clr; bus.M = m; bus.D = d; bus.SI_R = sir; bus.SI_L = sil;
    e.name = nm; e.q = eq; e.so = eso; e.tc = etc;
    exp_q.push_back(e);
  endtask

  initial begin
    bus.EN = 1'b0; bus.CLR = 1'b0; bus.M = 3'b000; bus.D = 4'h0; bus.SI_R = 1'b0; bus.SI_L = 1'b0;

    //    name          R  EN CLR M       D     SIR SIL  Q     SO   TC
    step("rst_async",  0, 0, 0, 3'b000, 4'h0, 0, 0, 4'hA, 1'b0, 1'b0);
    step("rst_release",1, 0, 0, 3'b000, 4'h0, 0, 0, 4'hA, 1'b0, 1'b0);
    step("load_3",     1, 1, 0, 3'b001, 4'h3, 0, 0, 4'hA, 1'b0, 1'b0);
    step("hold_1",     1, 0, 0, 3'b100, 4'h0, 0, 0, 4'h3, 1'b1, 1'b0);
    step("hold_2",     1, 0, 0, 3'b100, 4'h0, 0, 0, 4'h3, 1'b1, 1'b0);
    step("hold_3",     1, 0, 0, 3'b100, 4'h0, 0, 0, 4'h3, 1'b1, 1'b0);
    step("load_E",     1, 1, 0, 3'b001, 4'hE, 0, 0, 4'h3, 1'b1, 1'b0);
    step("up_E",       1, 1, 0, 3'b100, 4'h0, 0, 0, 4'hE, 1'b0, 1'b0);
    step("up_F_tc",    1, 1, 0, 3'b100, 4'h0, 0, 0, 4'hF, 1'b1, 1'b1);
    step("up_wrap0",   1, 1, 0, 3'b001, 4'h0, 0, 0, 4'h0, 1'b0, 1'b0);
    step("dn_0_tc",    1, 1, 0, 3'b101, 4'h0, 0, 0, 4'h0, 1'b0, 1'b1);
    step("dn_wrapF",   1, 1, 0, 3'b001, 4'h9, 0, 0, 4'hF, 1'b1, 1'b0);
    step("shl_9",      1, 1, 0, 3'b010, 4'h0, 0, 0, 4'h9, 1'b1, 1'b0);
    step("shr_2",      1, 1, 0, 3'b011, 4'h0, 0, 1, 4'h2, 1'b0, 1'b0);
    step("rol_9",      1, 1, 0, 3'b110, 4'h0, 0, 0, 4'h9, 1'b1, 1'b0);
    step("ror_3",      1, 1, 0, 3'b111, 4'h0, 0, 0, 4'h3, 1'b1, 1'b0);
    step("load_5",     1, 1, 0, 3'b001, 4'h5, 0, 0, 4'h9, 1'b1, 1'b0);
    step("clr_en0",    1, 0, 1, 3'b100, 4'h0, 0, 0, 4'h5, 1'b1, 1'b0);
    step("load_F",     1, 1, 0, 3'b001, 4'hF, 0, 0, 4'hA, 1'b0, 1'b0);
    step("clr_tc",     1, 1, 1, 3'b100, 4'h0, 0, 0, 4'hF, 1'b1, 1'b0);
    step("load_0",     1, 1, 0, 3'b001, 4'h0, 0, 0, 4'hA, 1'b0, 1'b0);
    step("cnt_0",      1, 1, 0, 3'b100, 4'h0, 0, 0, 4'h0, 1'b0, 1'b0);
    step("cnt_1",      1, 1, 0, 3'b100, 4'h0, 0, 0, 4'h1, 1'b1, 1'b0);
    step("rst_mid",    0, 1, 0, 3'b100, 4'h0, 0, 0, 4'hA, 1'b0, 1'b0);
    step("rst_hold",   0, 1, 0, 3'b100, 4'h0, 0, 0, 4'hA, 1'b0, 1'b0);
    step("rst_rel",    1, 1, 0, 3'b100, 4'h0, 0, 0, 4'hA, 1'b0, 1'b0);
    step("resume_B",   1, 1, 0, 3'b100, 4'h0, 0, 0, 4'hB, 1'b1, 1'b0);
    step("resume_C",   1, 1, 0, 3'b100, 4'h0, 0, 0, 4'hC, 1'b0, 1'b0);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge C);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
